// File: rtl/xbar_cfg_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : xbar_cfg_loader_if
// Description : Bundle of the crossbar configuration port. Carries the
//               per-output select write channel (valid/ready), the init
//               request, the commit handshake, the active configuration bus
//               and the status/error flags.
//               master : the configuring agent (drives requests)
//               slave  : xbar_cfg_loader (drives readies, status, config)
// Revision    : 1.0 - initial release
// ============================================================================
interface xbar_cfg_loader_if #(
    parameter int N_OUT  = 42,
    parameter int SEL_W  = 5,
    parameter int ADDR_W = 6
) ();
    // Select write channel
    logic                   io_cfg_valid;
    logic                   io_cfg_ready;
    logic [ADDR_W-1:0]      io_cfg_addr;
    logic [SEL_W-1:0]       io_cfg_sel;
    // Default-pattern fill request
    logic                   io_init;
    // Commit handshake
    logic                   io_commit_valid;
    logic                   io_commit_ready;
    logic                   io_commit_done;
    // Active configuration towards the crossbar
    logic [N_OUT*SEL_W-1:0] io_mux_configs;
    // Status
    logic                   io_busy;
    logic                   io_dirty;
    logic                   io_err;
    logic                   io_err_clr;

    modport master (
        output io_cfg_valid, io_cfg_addr, io_cfg_sel, io_init,
               io_commit_valid, io_err_clr,
        input  io_cfg_ready, io_commit_ready, io_commit_done,
               io_mux_configs, io_busy, io_dirty, io_err
    );

    modport slave (
        input  io_cfg_valid, io_cfg_addr, io_cfg_sel, io_init,
               io_commit_valid, io_err_clr,
        output io_cfg_ready, io_commit_ready, io_commit_done,
               io_mux_configs, io_busy, io_dirty, io_err
    );
endinterface
`default_nettype wire

// File: rtl/xbar_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : xbar_cfg_loader
// Description : Configuration controller for the tile crossbar. Select
//               writes land in a shadow register file; an init sweep can
//               fill the shadow with the pattern entry i = i mod N_IN; a
//               one-cycle commit copies the whole shadow into the active
//               register that drives io_mux_configs, so the crossbar never
//               observes a half-written configuration.
// Ports       : clk   - clock
//               reset - asynchronous active-low reset
//               bus   - xbar_cfg_loader_if.slave (write, init, commit,
//                       active config, busy/dirty/err status)
// Revision    : 1.0 - initial release
// ============================================================================
module xbar_cfg_loader #(
    parameter int N_IN   = 31,
    parameter int N_OUT  = 42,
    parameter int SEL_W  = 5,
    parameter int ADDR_W = 6
) (
    input  wire logic         clk,
    input  wire logic         reset,
    xbar_cfg_loader_if.slave  bus
);

    // Limits widened by one bit so the range checks stay correct even when
    // N_OUT or N_IN equals the full power of two of the field width.
    localparam logic [ADDR_W:0]   c_n_out    = (ADDR_W+1)'(N_OUT);
    localparam logic [SEL_W:0]    c_n_in     = (SEL_W+1)'(N_IN);
    localparam logic [ADDR_W-1:0] c_idx_last = ADDR_W'(N_OUT - 1);
    localparam logic [SEL_W-1:0]  c_sel_last = SEL_W'(N_IN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_INIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ADDR_W-1:0]      r_idx;
    logic [SEL_W-1:0]       r_init_sel;   // tracks idx mod N_IN without a divider
    logic [SEL_W-1:0]       r_shadow [N_OUT];
    logic [N_OUT*SEL_W-1:0] r_active;
    logic                   r_commit_done;
    logic                   r_dirty;
    logic                   r_err;

    logic                   w_commit_ready;
    logic                   w_cfg_ready;
    logic                   w_commit_fire;
    logic                   w_cfg_fire;
    logic                   w_cfg_legal;
    logic [N_OUT*SEL_W-1:0] w_shadow_flat;

    // ------------------------------------------------------------------
    // Flatten the shadow file into the bus layout used by io_mux_configs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_pack
        assign w_shadow_flat[gi*SEL_W +: SEL_W] = r_shadow[gi];
    end

    // ------------------------------------------------------------------
    // Handshakes: init outranks commit, commit outranks a write
    // ------------------------------------------------------------------
    assign w_commit_ready = (r_state == S_IDLE) && !bus.io_init;
    assign w_cfg_ready    = w_commit_ready && !bus.io_commit_valid;
    assign w_commit_fire  = bus.io_commit_valid && w_commit_ready;
    assign w_cfg_fire     = bus.io_cfg_valid && w_cfg_ready;
    assign w_cfg_legal    = ({1'b0, bus.io_cfg_addr} < c_n_out) &&
                            ({1'b0, bus.io_cfg_sel}  < c_n_in);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.io_init) begin
                    w_state_next = S_INIT;
                end else if (w_commit_fire) begin
                    w_state_next = S_COMMIT;
                end
            end
            S_INIT: begin
                if (r_idx == c_idx_last) begin
                    w_state_next = S_IDLE;
                end
            end
            S_COMMIT: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_init_sel    <= '0;
            r_active      <= '0;
            r_commit_done <= 1'b0;
            r_dirty       <= 1'b0;
            r_err         <= 1'b0;
            for (int i = 0; i < N_OUT; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_state       <= w_state_next;
            r_commit_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.io_init) begin
                        r_idx      <= '0;
                        r_init_sel <= '0;
                    end else if (w_cfg_fire && w_cfg_legal) begin
                        r_shadow[bus.io_cfg_addr] <= bus.io_cfg_sel;
                        r_dirty                   <= 1'b1;
                    end
                end
                S_INIT: begin
                    r_shadow[r_idx] <= r_init_sel;
                    r_idx           <= r_idx + 1'b1;
                    r_init_sel      <= (r_init_sel == c_sel_last) ? '0
                                                                  : r_init_sel + 1'b1;
                    r_dirty         <= 1'b1;
                end
                S_COMMIT: begin
                    r_active      <= w_shadow_flat;
                    r_dirty       <= 1'b0;
                    r_commit_done <= 1'b1;
                end
                default: begin
                end
            endcase

            // A failing write in the same cycle as a clear leaves the flag set
            if (w_cfg_fire && !w_cfg_legal) begin
                r_err <= 1'b1;
            end else if (bus.io_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.io_cfg_ready    = w_cfg_ready;
    assign bus.io_commit_ready = w_commit_ready;
    assign bus.io_commit_done  = r_commit_done;
    assign bus.io_mux_configs  = r_active;
    assign bus.io_busy         = (r_state != S_IDLE);
    assign bus.io_dirty        = r_dirty;
    assign bus.io_err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_xbar_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_xbar_cfg_loader
// Description : Directed self-checking bench for xbar_cfg_loader. Inputs
//               change 1 ns after a rising edge; outputs are sampled there.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xbar_cfg_loader;

    localparam int c_n_in  = 31;
    localparam int c_n_out = 42;
    localparam int c_sel_w = 5;
    localparam int c_w     = c_n_out * c_sel_w;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [c_w-1:0] r_exp;

    xbar_cfg_loader_if #(.N_OUT(c_n_out), .SEL_W(c_sel_w), .ADDR_W(6)) bus ();

    xbar_cfg_loader #(
        .N_IN  (c_n_in),
        .N_OUT (c_n_out),
        .SEL_W (c_sel_w),
        .ADDR_W(6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int addr, input int sel);
        bus.io_cfg_valid = 1'b1;
        bus.io_cfg_addr  = 6'(addr);
        bus.io_cfg_sel   = 5'(sel);
        step();
        bus.io_cfg_valid = 1'b0;
    endtask

    function automatic logic [4:0] entry(input int i);
        logic [c_w-1:0] v;
        v = bus.io_mux_configs;
        return v[i*c_sel_w +: c_sel_w];
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        n_tests++;
        if (bus.io_mux_configs !== '0 || bus.io_busy !== 1'b0 || bus.io_dirty !== 1'b0 ||
            bus.io_err !== 1'b0 || bus.io_commit_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: cfg=%h busy=%b dirty=%b err=%b done=%b expected all 0",
                     bus.io_mux_configs, bus.io_busy, bus.io_dirty, bus.io_err, bus.io_commit_done);
        end
        n_tests++;
        if (bus.io_cfg_ready !== 1'b1 || bus.io_commit_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: cfg_ready=%b commit_ready=%b expected 1 1",
                     bus.io_cfg_ready, bus.io_commit_ready);
        end
        // Build some state, then reset mid-stream
        do_write(3, 7);
        bus.io_commit_valid = 1'b1;
        step();
        bus.io_commit_valid = 1'b0;
        step();
        r_exp = '0;
        r_exp[19:15] = 5'd7;
        n_tests++;
        if (bus.io_mux_configs !== r_exp) begin
            n_fail++;
            $display("FAIL reset_pre_commit: cfg=%h expected %h", bus.io_mux_configs, r_exp);
        end
        do_write(5, 2);
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if (bus.io_mux_configs !== '0 || bus.io_dirty !== 1'b0 || bus.io_busy !== 1'b0 ||
            bus.io_cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midstream: cfg=%h dirty=%b busy=%b cfg_ready=%b expected 0 0 0 1",
                     bus.io_mux_configs, bus.io_dirty, bus.io_busy, bus.io_cfg_ready);
        end
        @(negedge clk) reset = 1'b1;
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_write_commit();
        n_tests++;
        if (bus.io_cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wc_ready: cfg_ready=%b expected 1", bus.io_cfg_ready);
        end
        // Back-to-back writes
        bus.io_cfg_valid = 1'b1;
        bus.io_cfg_addr  = 6'd3;
        bus.io_cfg_sel   = 5'd17;
        step();
        bus.io_cfg_addr  = 6'd41;
        bus.io_cfg_sel   = 5'd30;
        step();
        bus.io_cfg_valid = 1'b0;
        n_tests++;
        if (bus.io_dirty !== 1'b1 || bus.io_mux_configs !== '0) begin
            n_fail++;
            $display("FAIL wc_shadow_only: dirty=%b cfg=%h expected 1 and 0",
                     bus.io_dirty, bus.io_mux_configs);
        end
        bus.io_commit_valid = 1'b1;
        n_tests++;
        if (bus.io_commit_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wc_commit_ready: got %b expected 1", bus.io_commit_ready);
        end
        step();
        bus.io_commit_valid = 1'b0;
        n_tests++;
        if (bus.io_busy !== 1'b1 || bus.io_commit_done !== 1'b0 || bus.io_mux_configs !== '0) begin
            n_fail++;
            $display("FAIL wc_commit_cycle: busy=%b done=%b cfg=%h expected 1 0 0",
                     bus.io_busy, bus.io_commit_done, bus.io_mux_configs);
        end
        step();
        r_exp = '0;
        r_exp[19:15]   = 5'd17;
        r_exp[209:205] = 5'd30;
        n_tests++;
        if (bus.io_commit_done !== 1'b1 || bus.io_busy !== 1'b0 || bus.io_dirty !== 1'b0 ||
            bus.io_mux_configs !== r_exp) begin
            n_fail++;
            $display("FAIL wc_done: done=%b busy=%b dirty=%b cfg=%h expected 1 0 0 %h",
                     bus.io_commit_done, bus.io_busy, bus.io_dirty, bus.io_mux_configs, r_exp);
        end
        step();
        n_tests++;
        if (bus.io_commit_done !== 1'b0) begin
            n_fail++;
            $display("FAIL wc_done_pulse: done=%b expected 0", bus.io_commit_done);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_illegal();
        do_write(42, 1);
        n_tests++;
        if (bus.io_err !== 1'b1 || bus.io_dirty !== 1'b0) begin
            n_fail++;
            $display("FAIL ill_addr: err=%b dirty=%b expected 1 0", bus.io_err, bus.io_dirty);
        end
        do_write(0, 31);
        step();
        step();
        n_tests++;
        if (bus.io_err !== 1'b1 || bus.io_dirty !== 1'b0) begin
            n_fail++;
            $display("FAIL ill_sel_sticky: err=%b dirty=%b expected 1 0", bus.io_err, bus.io_dirty);
        end
        bus.io_commit_valid = 1'b1;
        step();
        bus.io_commit_valid = 1'b0;
        step();
        n_tests++;
        if (bus.io_mux_configs !== r_exp || bus.io_commit_done !== 1'b1) begin
            n_fail++;
            $display("FAIL ill_commit: cfg=%h done=%b expected %h 1",
                     bus.io_mux_configs, bus.io_commit_done, r_exp);
        end
        bus.io_err_clr = 1'b1;
        step();
        bus.io_err_clr = 1'b0;
        n_tests++;
        if (bus.io_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ill_clear: err=%b expected 0", bus.io_err);
        end
        // Set wins over a simultaneous clear
        bus.io_err_clr = 1'b1;
        do_write(63, 0);
        bus.io_err_clr = 1'b0;
        n_tests++;
        if (bus.io_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ill_set_wins: err=%b expected 1", bus.io_err);
        end
        bus.io_err_clr = 1'b1;
        step();
        bus.io_err_clr = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_init_commit();
        int  cnt;
        logic bad_ready;
        logic [c_w-1:0] pre;
        pre = bus.io_mux_configs;
        bus.io_init      = 1'b1;
        bus.io_cfg_valid = 1'b1;
        bus.io_cfg_addr  = 6'd5;
        bus.io_cfg_sel   = 5'd1;
        #1;
        n_tests++;
        if (bus.io_cfg_ready !== 1'b0 || bus.io_commit_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL init_ready_block: cfg_ready=%b commit_ready=%b expected 0 0",
                     bus.io_cfg_ready, bus.io_commit_ready);
        end
        step();
        bus.io_init = 1'b0;
        cnt = 0;
        bad_ready = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (bus.io_busy !== 1'b1) break;
            cnt++;
            if (bus.io_cfg_ready !== 1'b0) bad_ready = 1'b1;
            step();
        end
        bus.io_cfg_valid = 1'b0;
        n_tests++;
        if (cnt != c_n_out || bad_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL init_busy: busy_cycles=%0d ready_seen=%b expected %0d 0",
                     cnt, bad_ready, c_n_out);
        end
        n_tests++;
        if (bus.io_mux_configs !== pre || bus.io_dirty !== 1'b1) begin
            n_fail++;
            $display("FAIL init_no_active: cfg=%h dirty=%b expected %h 1",
                     bus.io_mux_configs, bus.io_dirty, pre);
        end
        bus.io_commit_valid = 1'b1;
        step();
        bus.io_commit_valid = 1'b0;
        step();
        for (int i = 0; i < c_n_out; i++) r_exp[i*c_sel_w +: c_sel_w] = 5'(i % c_n_in);
        n_tests++;
        if (entry(30) !== 5'd30 || entry(31) !== 5'd0 || entry(41) !== 5'd10) begin
            n_fail++;
            $display("FAIL init_entries: e30=%0d e31=%0d e41=%0d expected 30 0 10",
                     entry(30), entry(31), entry(41));
        end
        n_tests++;
        if (bus.io_mux_configs !== r_exp) begin
            n_fail++;
            $display("FAIL init_pattern: cfg=%h expected %h", bus.io_mux_configs, r_exp);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_simultaneous();
        int cnt;
        do_write(0, 9);
        bus.io_init         = 1'b1;
        bus.io_commit_valid = 1'b1;
        bus.io_cfg_valid    = 1'b1;
        bus.io_cfg_addr     = 6'd2;
        bus.io_cfg_sel      = 5'd4;
        #1;
        n_tests++;
        if (bus.io_cfg_ready !== 1'b0 || bus.io_commit_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_ready: cfg_ready=%b commit_ready=%b expected 0 0",
                     bus.io_cfg_ready, bus.io_commit_ready);
        end
        step();
        bus.io_init      = 1'b0;
        bus.io_cfg_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 60; k++) begin
            if (bus.io_commit_ready === 1'b1) break;
            cnt++;
            step();
        end
        n_tests++;
        if (cnt != c_n_out) begin
            n_fail++;
            $display("FAIL simul_wait: cycles_until_ready=%0d expected %0d", cnt, c_n_out);
        end
        step();
        bus.io_commit_valid = 1'b0;
        n_tests++;
        if (bus.io_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_commit: busy=%b expected 1", bus.io_busy);
        end
        step();
        n_tests++;
        if (bus.io_commit_done !== 1'b1 || bus.io_mux_configs !== r_exp) begin
            n_fail++;
            $display("FAIL simul_result: done=%b cfg=%h expected 1 %h",
                     bus.io_commit_done, bus.io_mux_configs, r_exp);
        end
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_commit();
        logic seen_done;
        #1 reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        step();
        do_write(0, 5);
        bus.io_commit_valid = 1'b1;
        step();
        bus.io_commit_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if (bus.io_mux_configs !== '0 || bus.io_busy !== 1'b0 || bus.io_dirty !== 1'b0) begin
            n_fail++;
            $display("FAIL rc_abort: cfg=%h busy=%b dirty=%b expected 0 0 0",
                     bus.io_mux_configs, bus.io_busy, bus.io_dirty);
        end
        seen_done = 1'b0;
        @(negedge clk) reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.io_commit_done !== 1'b0) seen_done = 1'b1;
        end
        n_tests++;
        if (seen_done !== 1'b0 || bus.io_mux_configs !== '0) begin
            n_fail++;
            $display("FAIL rc_no_commit: done_seen=%b cfg=%h expected 0 0",
                     seen_done, bus.io_mux_configs);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        r_exp   = '0;
        reset               = 1'b0;
        bus.io_cfg_valid    = 1'b0;
        bus.io_cfg_addr     = '0;
        bus.io_cfg_sel      = '0;
        bus.io_init         = 1'b0;
        bus.io_commit_valid = 1'b0;
        bus.io_err_clr      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        step();

        test_reset();
        test_write_commit();
        test_illegal();
        test_init_commit();
        test_simultaneous();
        test_reset_commit();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
